// File: rtl/convert_from_bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
package convert_from_bcd_pkg;

  localparam int unsigned DIGITS_DEF = 4;
  localparam int unsigned NIBBLE_W   = 4;

  localparam logic [NIBBLE_W-1:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [NIBBLE_W-1:0] ADJ_THRESHOLD = 4'd8;
  localparam logic [NIBBLE_W-1:0] ADJ_VALUE     = 4'd3;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

endpackage

// File: rtl/convert_from_bcd_digit_adjust.sv
// Per-nibble correction step of reverse double-dabble: nibbles >= 8 lose 3.
module bcd_digit_adjust
  import convert_from_bcd_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_digit,
  output logic [NIBBLE_W-1:0] o_digit_c
);

  always_comb begin
    o_digit_c = i_digit;
    if (i_digit >= ADJ_THRESHOLD) begin
      o_digit_c = i_digit - ADJ_VALUE;
    end
  end

endmodule

// File: rtl/convert_from_bcd.sv
// Packed-BCD to unsigned binary converter, one bit per clock via
// shift-right / subtract-3; invalid digits complete immediately with err.
module convert_from_bcd
  import convert_from_bcd_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NIBBLE_W*DIGITS-1:0] bcd_in,
  output logic                       busy,
  output logic                       done,
  output logic [NIBBLE_W*DIGITS-1:0] bin_out,
  output logic                       err
);

  localparam int unsigned W     = NIBBLE_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(W) + 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2*W-1:0]   r_work;
  logic [2*W-1:0]   w_work_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic [W-1:0]     r_bin;
  logic [W-1:0]     w_bin_nxt;

  logic [2*W-1:0]   w_shift;
  logic [W-1:0]     w_adj_hi;
  logic [2*W-1:0]   w_step;
  logic [DIGITS-1:0] w_digit_bad;
  logic             w_in_valid;

  // One iteration: shift the whole work register, then correct each upper nibble
  assign w_shift = r_work >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adjust u_adj (
      .i_digit   (w_shift[W + NIBBLE_W*g +: NIBBLE_W]),
      .o_digit_c (w_adj_hi[NIBBLE_W*g +: NIBBLE_W])
    );

    assign w_digit_bad[g] = (bcd_in[NIBBLE_W*g +: NIBBLE_W] > BCD_MAX_DIGIT);
  end

  assign w_step     = {w_adj_hi, w_shift[W-1:0]};
  assign w_in_valid = ~|w_digit_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_work_nxt  = r_work;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_bin_nxt   = r_bin;

    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_in_valid) begin
            w_state_nxt = CONV;
            w_work_nxt  = {bcd_in, W'(0)};
            w_cnt_nxt   = '0;
            w_err_nxt   = 1'b0;
            w_busy_nxt  = 1'b1;
          end else begin
            // Bad digit: report on the accepting edge without converting
            w_err_nxt  = 1'b1;
            w_bin_nxt  = '0;
            w_done_nxt = 1'b1;
          end
        end
      end

      CONV: begin
        w_work_nxt = w_step;
        w_cnt_nxt  = r_cnt + CNT_W'(1);
        w_busy_nxt = 1'b1;
        if (r_cnt == CNT_W'(W - 1)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_bin_nxt   = w_step[W-1:0];
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_work <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_bin  <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_work <= w_work_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      r_bin  <= w_bin_nxt;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign bin_out = r_bin;

endmodule

// File: tb/tb_convert_from_bcd.sv
// Self-checking bench for convert_from_bcd against a decimal-arithmetic model.
module tb_convert_from_bcd;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] bcd_in;
  logic         busy;
  logic         done;
  logic [W-1:0] bin_out;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  convert_from_bcd #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic bit model_valid(input logic [W-1:0] b);
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int model_dec(input logic [W-1:0] b);
    int v = 0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      v = v * 10 + int'(b[4*i +: 4]);
    end
    return v;
  endfunction

  // Called at a negedge; returns at the negedge where done is observed
  task automatic do_op(input logic [W-1:0] b, input string tag);
    int  n;
    int  nb;
    bit  v;
    n      = 0;
    nb     = 0;
    start  = 1'b1;
    bcd_in = b;
    while (1) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (busy) nb++;
      if (done || n >= 4 * int'(W)) break;
    end
    v = model_valid(b);
    chk({tag, "/done_seen"}, 32'(done), 32'd1);
    chk({tag, "/bin"}, 32'(bin_out), v ? 32'(model_dec(b)) : 32'd0);
    chk({tag, "/err"}, 32'(err), v ? 32'd0 : 32'd1);
    chk({tag, "/latency"}, 32'(n), v ? 32'(W + 1) : 32'd1);
    chk({tag, "/busy_cycles"}, 32'(nb), v ? 32'(W) : 32'd0);
  endtask

  initial begin
    int nb;
    int nd;
    logic [W-1:0] b;

    rst_n  = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/err",  32'(err),  32'd0);
    chk("rst/bin",  32'(bin_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'h9999, "max");
    @(negedge clk);
    chk("max/done_pulse", 32'(done), 32'd0);
    chk("max/bin_hold", 32'(bin_out), 32'h270F);

    do_op(16'h1234, "b2b_a");
    do_op(16'h0000, "b2b_b");

    @(negedge clk);
    do_op(16'h12A4, "bad");
    @(negedge clk);
    chk("bad/done_pulse", 32'(done), 32'd0);
    chk("bad/err_hold", 32'(err), 32'd1);
    do_op(16'h0001, "after_bad");

    // Second start during CONV must be ignored
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0500;
    nb     = 0;
    nd     = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 5) begin start = 1'b1; bcd_in = 16'h0999; end
      if (c == 6) start = 1'b0;
      if (busy) nb++;
      if (done) begin
        nd++;
        chk("ignore/latency", 32'(c), 32'(W + 1));
        chk("ignore/bin", 32'(bin_out), 32'd500);
      end
    end
    chk("ignore/done_count", 32'(nd), 32'd1);
    chk("ignore/busy_cycles", 32'(nb), 32'(W));

    // Reset in the middle of a conversion
    start  = 1'b1;
    bcd_in = 16'h0042;
    nd     = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done) nd++;
    end
    chk("midrst/busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst/busy", 32'(busy), 32'd0);
    chk("midrst/bin",  32'(bin_out), 32'd0);
    chk("midrst/err",  32'(err), 32'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (c == 3) rst_n = 1'b1;
    end
    chk("midrst/no_done", 32'(nd), 32'd0);
    chk("midrst/bin_idle", 32'(bin_out), 32'd0);
    do_op(16'h0042, "after_rst");

    // Randomised back-to-back operands, mostly valid with some raw words
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(9) == 0) begin
        b = W'($urandom);
      end else begin
        for (int d = 0; d < int'(DIGITS); d++) b[4*d +: 4] = 4'($urandom_range(9));
      end
      do_op(b, "rnd");
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
